sig_monitor: RTL
================

Name: sig_monitor

Overview:
- Snoops the single_cycle core's data-memory write port and mirrors the RV32I compliance signature window into local registers.
- Detects the program's tohost completion write, or a cycle timeout, then streams the captured signature over a valid/ready interface.
- Sits directly downstream of the core's data-memory write bus, in parallel with u_dmem. It replaces hierarchical peeking into dmem contents from benches and FPGA wrappers.

Parameters:
- SIG_BASE, 32'h0000_1000, byte address of signature word 0 (word aligned).
- SIG_WORDS, 8, number of signature words captured (1..16).
- TOHOST_ADDR, 32'h0000_0FFC, byte address whose write ends the test.
- TIMEOUT, 200, cycles after reset release before a forced end; 0 disables the timeout.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_we  in  1  dmem write enable, sampled on the rising edge.
- mem_addr  in  32  dmem byte address; bits [1:0] are ignored.
- mem_wdata  in  32  dmem write data, little-endian lanes.
- mem_wstrb  in  4  byte enables; a lane is written only if its bit is 1.
- halt  out  1  asks the core to stop committing; high in DUMP and DONE.
- sig_valid  out  1  sig_data/sig_index are valid.
- sig_ready  in  1  sink accepts the word when sig_valid && sig_ready.
- sig_data  out  32  signature word.
- sig_index  out  4  index of the current word (0..SIG_WORDS-1).
- sig_unwritten  out  1  the current word had no byte written during RUN.
- done  out  1  sticky; the dump is complete.
- pass  out  1  sticky, qualified by done; tohost value was 1.
- fail_code  out  31  tohost value >> 1 on failure; all ones on timeout.

Behaviour:
- Reset (async assert, sync release) clears:
  - all outputs to 0;
  - the signature registers and per-word written flags to 0;
  - the cycle counter to 0;
  - state to RUN.
- States: RUN -> DUMP -> DONE. DONE holds until reset.
- RUN, signature capture:
  - Capture when mem_we=1 and SIG_BASE <= {addr[31:2],2'b00} < SIG_BASE+4*SIG_WORDS.
  - Word index = (addr-SIG_BASE)>>2.
  - Each lane with wstrb[i]=1 takes wdata[8i+7:8i]; other lanes keep their value. The word's written flag is set.
  - A capture is visible in the next cycle.
- RUN, tohost write (mem_we=1, word address equals TOHOST_ADDR):
  - Latch pass = (wdata==1).
  - Latch fail_code = wdata[31:1] when wdata != 1.
  - Next state DUMP. The byte strobe is ignored for tohost.
  - wdata=0 counts as fail with fail_code=0.
- RUN, counter and timeout:
  - The counter increments every cycle in RUN.
  - When the counter reaches TIMEOUT-1 without a tohost write: pass=0, fail_code=all ones, next state DUMP.
  - If a tohost write and the timeout occur in the same cycle, the tohost write wins.
- DUMP:
  - halt=1.
  - sig_index starts at 0 and sig_valid=1 from the first DUMP cycle.
  - sig_data, sig_index and sig_unwritten are held stable while sig_valid && !sig_ready.
  - On each handshake the index increments.
  - The handshake on index SIG_WORDS-1 moves the state to DONE; sig_valid drops in the next cycle.
  - Throughput is 1 word per cycle with sig_ready tied high, so the dump takes exactly SIG_WORDS cycles.
- DONE: halt=1, done=1, sig_valid=0. pass and fail_code are held.
- All dmem writes in DUMP or DONE are ignored: no capture and no re-trigger.
- rst_n asserted mid-dump aborts immediately to the reset state. Partially streamed data is not resent until the next test ends.
- The counter is 32-bit and saturates; it never wraps.

Decomposition:
- Package sig_monitor_pkg:
  - state enum sig_state_e {S_RUN, S_DUMP, S_DONE};
  - localparams for the defaults;
  - a function for word-in-window index decode.
- One natural sub-module, sig_byte_reg: one 32-bit word with per-lane strobe write and a written flag. Instantiated SIG_WORDS times with a generate loop.

Test Plan:
- Writes of 0x11111111..0x88888888 to 0x1000..0x101C, then tohost=1 with sig_ready=1:
  - words streamed in index order 0..7 with those values, 8 consecutive valid cycles;
  - pass=1, done=1, halt stays 1.
- Write 0xAABBCCDD to 0x1004 with wstrb=4'b0101, then tohost=1:
  - sig[1]=0x00BB00DD, sig_unwritten=0;
  - all other words 0 with sig_unwritten=1.
- sig_ready toggled 1,0,0,1,... during the dump:
  - data and index are stable while stalled;
  - exactly 8 handshakes;
  - done rises one cycle after the last handshake.
- No tohost write, TIMEOUT=200:
  - DUMP entered after cycle 199 of RUN;
  - pass=0, fail_code=0x7FFFFFFF.
- tohost=7:
  - pass=0, fail_code=3;
  - a later write to 0x1000 during DUMP leaves sig[0] unchanged.
- rst_n pulsed low while sig_index=3 in DUMP:
  - all outputs are 0 immediately;
  - state returns to RUN and the signature registers are cleared.

Source files
------------

// File: rtl/sig_monitor_pkg.sv
// Shared types, default parameters and the signature-window decode helper for sig_monitor.
package sig_monitor_pkg;

    typedef enum logic [1:0] {
        S_RUN,
        S_DUMP,
        S_DONE
    } sig_state_e;

    localparam logic [31:0] SIG_BASE_DEF    = 32'h0000_1000;
    localparam int unsigned SIG_WORDS_DEF   = 8;
    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_0FFC;
    localparam int unsigned TIMEOUT_DEF     = 200;
    localparam int unsigned MAX_WORDS       = 16;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } win_hit_t;

    // Low address bits are dropped first so byte/halfword stores land in the right word.
    function automatic win_hit_t decode_window(input logic [31:0] addr,
                                               input logic [31:0] base,
                                               input int unsigned words);
        win_hit_t    res;
        logic [31:0] aligned;
        logic [31:0] offset;
        aligned = {addr[31:2], 2'b00};
        offset  = aligned - base;
        res.hit = (aligned >= base) && (offset < 32'(words * 4));
        res.idx = offset[5:2];
        return res;
    endfunction

endpackage

// File: rtl/sig_byte_reg.sv
// One signature word with per-byte-lane strobed writes and a sticky "written" flag.
module sig_byte_reg (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] word_o,
    output logic        written_o
);

    logic [31:0] word_q, word_d;
    logic        written_q, written_d;

    // The flag tracks whether any byte actually landed, so an all-zero strobe leaves it alone.
    always_comb begin
        word_d    = word_q;
        written_d = written_q;
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_i[i]) begin
                    word_d[8*i +: 8] = wdata_i[8*i +: 8];
                end
            end
            if (|wstrb_i) begin
                written_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q    <= '0;
            written_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            written_q <= written_d;
        end
    end

    assign word_o    = word_q;
    assign written_o = written_q;

endmodule

// File: rtl/sig_monitor.sv
// Snoops dmem writes to mirror the compliance signature, then streams it out once the test
// ends via tohost or timeout.
module sig_monitor
    import sig_monitor_pkg::*;
#(
    parameter logic [31:0] SIG_BASE    = SIG_BASE_DEF,
    parameter int unsigned SIG_WORDS   = SIG_WORDS_DEF,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        halt_o,
    output logic        sig_valid_o,
    input  logic        sig_ready_i,
    output logic [31:0] sig_data_o,
    output logic [3:0]  sig_index_o,
    output logic        sig_unwritten_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [30:0] fail_code_o
);

    sig_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        pass_q, pass_d;
    logic [30:0] fail_code_q, fail_code_d;

    win_hit_t    win;
    logic        in_run;
    logic        tohost_hit;
    logic        timeout_hit;
    logic        capture;
    logic [31:0] words   [MAX_WORDS];
    logic        written [MAX_WORDS];

    assign win         = decode_window(mem_addr_i, SIG_BASE, SIG_WORDS);
    assign in_run      = (state_q == S_RUN);
    assign tohost_hit  = in_run && mem_we_i && ({mem_addr_i[31:2], 2'b00} == TOHOST_ADDR);
    assign timeout_hit = in_run && (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));
    assign capture     = in_run && mem_we_i && win.hit;

    // Unused slots up to MAX_WORDS read as zero so the output mux index never leaves the array.
    for (genvar g = 0; g < MAX_WORDS; g++) begin : g_word
        if (g < SIG_WORDS) begin : g_real
            sig_byte_reg u_reg (
                .clk_i     (clk_i),
                .rst_ni    (rst_ni),
                .we_i      (capture && (win.idx == 4'(g))),
                .wstrb_i   (mem_wstrb_i),
                .wdata_i   (mem_wdata_i),
                .word_o    (words[g]),
                .written_o (written[g])
            );
        end else begin : g_pad
            assign words[g]   = '0;
            assign written[g] = 1'b0;
        end
    end

    // tohost is tested before the timeout so a coincident completion write is honoured.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pass_d      = pass_q;
        fail_code_d = fail_code_q;
        case (state_q)
            S_RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (tohost_hit) begin
                    pass_d      = (mem_wdata_i == 32'd1);
                    fail_code_d = (mem_wdata_i == 32'd1) ? '0 : mem_wdata_i[31:1];
                    state_d     = S_DUMP;
                end else if (timeout_hit) begin
                    pass_d      = 1'b0;
                    fail_code_d = '1;
                    state_d     = S_DUMP;
                end
            end
            S_DUMP: begin
                if (sig_ready_i) begin
                    if (idx_q == 4'(SIG_WORDS - 1)) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            idx_q       <= '0;
            pass_q      <= 1'b0;
            fail_code_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
        end
    end

    assign halt_o          = (state_q != S_RUN);
    assign sig_valid_o     = (state_q == S_DUMP);
    assign sig_data_o      = sig_valid_o ? words[idx_q] : '0;
    assign sig_index_o     = idx_q;
    assign sig_unwritten_o = sig_valid_o && !written[idx_q];
    assign done_o          = (state_q == S_DONE);
    assign pass_o          = pass_q;
    assign fail_code_o     = fail_code_q;

endmodule
